// File: rtl/red_pitaya_daisy_link_ctrl.sv
// rtl/red_pitaya_daisy_link_ctrl.sv - daisy-chain link bring-up sequencer
module red_pitaya_daisy_link_ctrl #(
    parameter int unsigned SETTLE_CYC = 64,
    parameter int unsigned TRAIN_TO   = 100000,
    parameter int unsigned CLR_CYC    = 16,
    parameter int unsigned TEST_LEN   = 4096,
    parameter int unsigned TEST_TO    = 1000000,
    parameter int unsigned ERR_THR    = 0,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic        sys_clk_i,
    input  logic        sys_rstn_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        rx_trained_i,
    input  logic [31:0] tst_err_cnt_i,
    input  logic [31:0] tst_dat_cnt_i,
    output logic        tx_en_o,
    output logic        rx_en_o,
    output logic [2:0]  tx_sel_o,
    output logic        rx_train_o,
    output logic        tst_clr_o,
    output logic        link_up_o,
    output logic        busy_o,
    output logic        fail_o,
    output logic [1:0]  retry_cnt_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENABLE = 3'd1,
        S_TRAIN  = 3'd2,
        S_CLEAR  = 3'd3,
        S_TEST   = 3'd4,
        S_UP     = 3'd5,
        S_FAIL   = 3'd6
    } state_t;

    // Terminal timer values: a state of length N exits when the timer reads N-1.
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] TRAIN_LAST  = 32'(TRAIN_TO - 1);
    localparam logic [31:0] CLR_LAST    = 32'(CLR_CYC - 1);
    localparam logic [31:0] TEST_LAST   = 32'(TEST_TO - 1);
    localparam logic [31:0] TEST_LEN_L  = 32'(TEST_LEN);
    localparam logic [31:0] ERR_THR_L   = 32'(ERR_THR);
    localparam logic [1:0]  MAX_RETRY_L = 2'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [1:0]  retry_q, retry_d;
    logic        trn_meta_q, trn_s_q;
    logic [31:0] dat_s1_q, dat_s2_q, err_s1_q, err_s2_q;
    logic        retry_go;
    logic        cnt_stable;
    logic        verdict;

    logic        tx_en_d, rx_en_d, rx_train_d, tst_clr_d, link_up_d, busy_d, fail_d;
    logic [2:0]  tx_sel_d;
    logic        tx_en_q, rx_en_q, rx_train_q, tst_clr_q, link_up_q, busy_q, fail_q;
    logic [2:0]  tx_sel_q;

    // Bring the RX-domain trained flag into sys_clk through two flops.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            trn_meta_q <= 1'b0;
            trn_s_q    <= 1'b0;
        end else begin
            trn_meta_q <= rx_trained_i;
            trn_s_q    <= trn_meta_q;
        end
    end

    // Keep two consecutive samples of each count; a value is trusted only when both agree.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            dat_s1_q <= '0;
            dat_s2_q <= '0;
            err_s1_q <= '0;
            err_s2_q <= '0;
        end else begin
            dat_s1_q <= tst_dat_cnt_i;
            dat_s2_q <= dat_s1_q;
            err_s1_q <= tst_err_cnt_i;
            err_s2_q <= err_s1_q;
        end
    end

    assign cnt_stable = (dat_s1_q == dat_s2_q) && (err_s1_q == err_s2_q);
    assign verdict    = cnt_stable && (dat_s1_q >= TEST_LEN_L);

    // Next-state and retry bookkeeping; abort overrides everything at the end.
    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        retry_go = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ENABLE;
                    retry_d = 2'd0;
                end
            end
            S_ENABLE: begin
                if (timer_q == SETTLE_LAST) state_d = S_TRAIN;
            end
            S_TRAIN: begin
                if (trn_s_q) state_d = S_CLEAR;
                else if (timer_q == TRAIN_LAST) retry_go = 1'b1;
            end
            S_CLEAR: begin
                if (timer_q == CLR_LAST) state_d = S_TEST;
            end
            S_TEST: begin
                if (verdict) begin
                    if (err_s1_q <= ERR_THR_L) state_d = S_UP;
                    else retry_go = 1'b1;
                end else if ((timer_q == TEST_LAST) || !trn_s_q) begin
                    retry_go = 1'b1;
                end
            end
            S_UP: begin
                if (!trn_s_q) begin
                    state_d = S_ENABLE;
                    retry_d = 2'd0;
                end
            end
            S_FAIL: begin
                if (start_i) begin
                    state_d = S_ENABLE;
                    retry_d = 2'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (retry_go) begin
            if (retry_q == MAX_RETRY_L) begin
                state_d = S_FAIL;
            end else begin
                state_d = S_ENABLE;
                retry_d = retry_q + 2'd1;
            end
        end
        if (abort_i) begin
            state_d = S_IDLE;
            retry_d = 2'd0;
        end
    end

    // Timer restarts on each state entry and saturates while a timed state runs.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if ((state_q == S_ENABLE || state_q == S_TRAIN ||
                      state_q == S_CLEAR  || state_q == S_TEST) && (timer_q != '1)) begin
            timer_d = timer_q + 32'd1;
        end
    end

    // Output decode from the next state so outputs move with state_o.
    always_comb begin
        tx_en_d    = 1'b0;
        rx_en_d    = 1'b0;
        tx_sel_d   = 3'd0;
        rx_train_d = 1'b0;
        tst_clr_d  = 1'b0;
        link_up_d  = 1'b0;
        busy_d     = 1'b0;
        fail_d     = 1'b0;
        unique case (state_d)
            S_ENABLE: begin
                tx_en_d = 1'b1; rx_en_d = 1'b1; tx_sel_d = 3'd3; busy_d = 1'b1;
            end
            S_TRAIN: begin
                tx_en_d = 1'b1; rx_en_d = 1'b1; tx_sel_d = 3'd3; rx_train_d = 1'b1; busy_d = 1'b1;
            end
            S_CLEAR: begin
                tx_en_d = 1'b1; rx_en_d = 1'b1; tx_sel_d = 3'd5; tst_clr_d = 1'b1; busy_d = 1'b1;
            end
            S_TEST: begin
                tx_en_d = 1'b1; rx_en_d = 1'b1; tx_sel_d = 3'd5; busy_d = 1'b1;
            end
            S_UP: begin
                tx_en_d = 1'b1; rx_en_d = 1'b1; tx_sel_d = 3'd1; link_up_d = 1'b1;
            end
            S_FAIL: begin
                fail_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State, timer, retry counter and registered outputs.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            retry_q    <= 2'd0;
            tx_en_q    <= 1'b0;
            rx_en_q    <= 1'b0;
            tx_sel_q   <= 3'd0;
            rx_train_q <= 1'b0;
            tst_clr_q  <= 1'b0;
            link_up_q  <= 1'b0;
            busy_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            tx_en_q    <= tx_en_d;
            rx_en_q    <= rx_en_d;
            tx_sel_q   <= tx_sel_d;
            rx_train_q <= rx_train_d;
            tst_clr_q  <= tst_clr_d;
            link_up_q  <= link_up_d;
            busy_q     <= busy_d;
            fail_q     <= fail_d;
        end
    end

    assign tx_en_o     = tx_en_q;
    assign rx_en_o     = rx_en_q;
    assign tx_sel_o    = tx_sel_q;
    assign rx_train_o  = rx_train_q;
    assign tst_clr_o   = tst_clr_q;
    assign link_up_o   = link_up_q;
    assign busy_o      = busy_q;
    assign fail_o      = fail_q;
    assign retry_cnt_o = retry_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_red_pitaya_daisy_link_ctrl.sv
// tb/tb_red_pitaya_daisy_link_ctrl.sv - self-checking bench for the daisy link sequencer
module tb_red_pitaya_daisy_link_ctrl;

    localparam int SETTLE    = 4;
    localparam int TRAIN_TO  = 100;
    localparam int CLR       = 16;
    localparam int TEST_LEN  = 1000;
    localparam int TEST_TO   = 5000;
    localparam int ERR_THR   = 0;
    localparam int MAX_RETRY = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        trained = 1'b0;
    logic [31:0] err = '0;
    logic [31:0] dat = '0;
    logic        tx_en, rx_en, rx_train, tst_clr, link_up, busy, fail;
    logic [2:0]  tx_sel, state;
    logic [1:0]  retry_cnt;
    logic [9:0]  dut_outs;

    int n_checks = 0;
    int n_fail   = 0;

    red_pitaya_daisy_link_ctrl #(
        .SETTLE_CYC(SETTLE), .TRAIN_TO(TRAIN_TO), .CLR_CYC(CLR), .TEST_LEN(TEST_LEN),
        .TEST_TO(TEST_TO), .ERR_THR(ERR_THR), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .sys_clk_i(clk), .sys_rstn_i(rst_n), .start_i(start), .abort_i(abort),
        .rx_trained_i(trained), .tst_err_cnt_i(err), .tst_dat_cnt_i(dat),
        .tx_en_o(tx_en), .rx_en_o(rx_en), .tx_sel_o(tx_sel), .rx_train_o(rx_train),
        .tst_clr_o(tst_clr), .link_up_o(link_up), .busy_o(busy), .fail_o(fail),
        .retry_cnt_o(retry_cnt), .state_o(state)
    );

    always #5 clk = ~clk;

    assign dut_outs = {tx_en, rx_en, tx_sel, rx_train, tst_clr, link_up, busy, fail};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output vector each state must present: {tx_en,rx_en,tx_sel,rx_train,tst_clr,link_up,busy,fail}.
    function automatic logic [9:0] exp_outs(input int s);
        case (s)
            1:       return 10'b11_011_00010;
            2:       return 10'b11_011_10010;
            3:       return 10'b11_101_01010;
            4:       return 10'b11_101_00010;
            5:       return 10'b11_001_00100;
            6:       return 10'b00_000_00001;
            default: return 10'b00_000_00000;
        endcase
    endfunction

    // Outcome of a retry decision taken with r retries already consumed.
    function automatic int retry_target(input int r);
        return (r == MAX_RETRY) ? 6 : 1;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int s);
        check_eq({tag, ".state"}, 32'(state), 32'(s));
        check_eq({tag, ".outs"}, 32'(dut_outs), 32'(exp_outs(s)));
    endtask

    task automatic count_in(input int s, input int budget, output int n);
        n = 0;
        while (32'(state) == 32'(s) && n < budget) begin
            n++;
            step(1);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic do_abort(input string tag);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check_state(tag, 0);
        check_eq({tag, ".retry"}, 32'(retry_cnt), 0);
    endtask

    // One attempt starting with ENABLE observed; d is the TRAIN cycle at which
    // trained is raised (1..TRAIN_TO-1), err_v the error count at the verdict.
    task automatic attempt(input int d, input logic [31:0] err_v, input int r_now,
                           input bit toggle, input bit poke, output int fin);
        int n;
        int exp_fin;
        logic [31:0] v;
        logic [31:0] fv;
        dat = '0;
        err = '0;
        trained = 1'b0;
        check_state("enable", 1);
        check_eq("enable.retry", 32'(retry_cnt), 32'(r_now));
        count_in(1, 50, n);
        check_eq("enable.len", 32'(n), 32'(SETTLE));
        check_state("train", 2);
        step(d);
        trained = 1'b1;
        count_in(2, 2 * TRAIN_TO, n);
        if (d + 3 > TRAIN_TO) begin
            check_eq("train.to_len", 32'(d + n), 32'(TRAIN_TO));
            exp_fin = retry_target(r_now);
            check_state("train.retry", exp_fin);
            if (exp_fin == 1) check_eq("train.retry_cnt", 32'(retry_cnt), 32'(r_now + 1));
            trained = 1'b0;
            fin = int'(state);
            return;
        end
        check_eq("train.sync_lat", 32'(n), 3);
        check_state("clear", 3);
        count_in(3, 100, n);
        check_eq("clear.len", 32'(n), 32'(CLR));
        check_state("test", 4);
        v = '0;
        repeat (4) begin
            v = v + 32'($urandom_range(100, 240));
            if (v > 32'(TEST_LEN - 1)) v = 32'(TEST_LEN - 1);
            dat = v;
            step($urandom_range(1, 3));
            check_eq("test.ramp", 32'(state), 4);
        end
        if (poke) begin
            pulse_start();
            check_eq("test.start_ignored", 32'(state), 4);
        end
        if (toggle) begin
            repeat ($urandom_range(4, 10)) begin
                dat = (dat == 32'(TEST_LEN - 1)) ? 32'(TEST_LEN) : 32'(TEST_LEN - 1);
                step(1);
                check_eq("test.unstable", 32'(state), 4);
            end
        end
        fv = 32'(TEST_LEN) + 32'($urandom_range(0, 3));
        if (fv == dat) fv = fv + 1;
        dat = fv;
        err = err_v;
        step(1);
        check_eq("test.lat1", 32'(state), 4);
        step(1);
        check_eq("test.lat2", 32'(state), 4);
        step(1);
        exp_fin = (err_v <= 32'(ERR_THR)) ? 5 : retry_target(r_now);
        check_state("verdict", exp_fin);
        if (exp_fin == 1) check_eq("verdict.retry_cnt", 32'(retry_cnt), 32'(r_now + 1));
        if (exp_fin != 5) trained = 1'b0;
        fin = int'(state);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fin;
        int n;
        int r;
        int guard;
        logic [31:0] e;

        // Reset
        step(3);
        check_state("reset", 0);
        check_eq("reset.retry", 32'(retry_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        check_state("idle", 0);

        // Nominal bring-up, then link loss, then unstable counts before verdict
        pulse_start();
        attempt(20, 0, 0, 1'b0, 1'b0, fin);
        check_eq("nominal.up", 32'(fin), 5);
        trained = 1'b0;
        step(1); check_eq("loss.hold1", 32'(state), 5);
        step(1); check_eq("loss.hold2", 32'(state), 5);
        step(1);
        check_state("loss.relink", 1);
        check_eq("loss.retry", 32'(retry_cnt), 0);
        attempt($urandom_range(1, 60), 0, 0, 1'b1, 1'b1, fin);
        check_eq("toggle.up", 32'(fin), 5);
        do_abort("abort_up");

        // Error verdict then clean pass
        pulse_start();
        attempt($urandom_range(1, 60), 5, 0, 1'b0, 1'b0, fin);
        check_eq("errv.retry", 32'(fin), 1);
        attempt($urandom_range(1, 60), 0, 1, 1'b0, 1'b0, fin);
        check_eq("errv.up", 32'(fin), 5);
        do_abort("abort_up2");

        // Abort mid TRAIN
        trained = 1'b0;
        pulse_start();
        count_in(1, 50, n);
        step($urandom_range(1, 90));
        check_eq("abort.in_train", 32'(state), 2);
        do_abort("abort_train");

        // Trained arriving one cycle late vs exactly on the timeout cycle
        pulse_start();
        attempt(TRAIN_TO - 2, 0, 0, 1'b0, 1'b0, fin);
        check_eq("bnd.late", 32'(fin), 1);
        attempt(TRAIN_TO - 3, 0, 1, 1'b0, 1'b0, fin);
        check_eq("bnd.ontime", 32'(fin), 5);
        do_abort("abort_bnd");

        // Training never completes: three timeouts then FAIL, then restart
        trained = 1'b0;
        pulse_start();
        for (int k = 0; k <= MAX_RETRY; k++) begin
            check_state("to.enable", 1);
            check_eq("to.retry", 32'(retry_cnt), 32'(k));
            count_in(1, 50, n);
            check_eq("to.enable_len", 32'(n), 32'(SETTLE));
            count_in(2, 2 * TRAIN_TO, n);
            check_eq("to.train_len", 32'(n), 32'(TRAIN_TO));
        end
        check_state("to.fail", 6);
        step(5);
        check_state("to.fail_hold", 6);
        pulse_start();
        check_state("to.restart", 1);
        check_eq("to.restart_retry", 32'(retry_cnt), 0);
        do_abort("abort_fail");

        // Randomized attempts against the retry model
        repeat (4) begin
            pulse_start();
            r = 0;
            guard = 0;
            fin = 1;
            while (fin == 1 && guard < 8) begin
                e = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : 32'd0;
                attempt($urandom_range(1, TRAIN_TO - 1), e, r, 1'($urandom_range(0, 1)),
                        1'b0, fin);
                if (fin == 1) r++;
                guard++;
            end
            check_eq("rand.final", 32'(fin == 5 || fin == 6), 1);
            do_abort("rand.abort");
        end

        // Asynchronous reset mid-sequence
        trained = 1'b0;
        pulse_start();
        step(SETTLE + 5);
        #3;
        rst_n = 1'b0;
        #1;
        check_state("areset", 0);
        check_eq("areset.retry", 32'(retry_cnt), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(3);
        check_state("areset.idle", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
